// File: rtl/div_unit_pkg.sv
// Shared types for the multi-cycle divider: FSM state encoding and default operand width.
package div_unit_pkg;

    localparam int unsigned DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial-subtract the divisor from the upper partial remainder, then shift.
module div_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] dividend_o
);

    logic [DATA_W:0] diff;

    always_comb begin
        diff = {1'b0, dividend_i[2*DATA_W-1:DATA_W]} - {1'b0, divisor_i};
        // Borrow out means the trial failed: keep the remainder and shift in a 0 quotient bit.
        if (diff[DATA_W]) begin
            dividend_o = {dividend_i[2*DATA_W-1:0], 1'b0};
        end else begin
            dividend_o = {diff[DATA_W-1:0], dividend_i[DATA_W-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU controller: FSM, iteration counter and sign fix-up around the div_step datapath.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W:0]   dividend_q, dividend_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                signed_q, signed_d;
    logic                neg1_q, neg1_d;
    logic                neg2_q, neg2_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic [2*DATA_W:0]   step_dividend;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W-1:0]   quot_raw, rem_raw;

    div_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .dividend_i(dividend_q),
        .divisor_i (divisor_q),
        .dividend_o(step_dividend)
    );

    always_comb begin
        abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
        quot_raw = dividend_q[DATA_W-1:0];
        rem_raw  = dividend_q[2*DATA_W:DATA_W+1];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signed_d   = signed_q;
        neg1_d     = neg1_q;
        neg2_d     = neg2_q;
        result_d   = result_q;

        unique case (state_q)
            DIV_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        cnt_d      = '0;
                        dividend_d = {{DATA_W{1'b0}}, abs1, 1'b0};
                        divisor_d  = abs2;
                        signed_d   = signed_div_i;
                        neg1_d     = opdata1_i[DATA_W-1];
                        neg2_d     = opdata2_i[DATA_W-1];
                    end
                end
            end
            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == CNT_W'(DATA_W)) begin
                    // Quotient sign follows the operand signs; remainder sign follows the dividend.
                    result_d[DATA_W-1:0] = (signed_q && (neg1_q ^ neg2_q)) ?
                                           (~quot_raw + 1'b1) : quot_raw;
                    result_d[2*DATA_W-1:DATA_W] = (signed_q && neg1_q) ?
                                                  (~rem_raw + 1'b1) : rem_raw;
                    state_d = DIV_END;
                end else begin
                    dividend_d = step_dividend;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            DIV_END: begin
                if (annul_i || !start_i) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            neg1_q     <= 1'b0;
            neg2_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signed_q   <= signed_d;
            neg1_q     <= neg1_d;
            neg2_q     <= neg2_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        ready_o  = (state_q == DIV_END);
        busy_o   = (state_q == DIV_BYZERO) || (state_q == DIV_ON);
        result_o = (state_q == DIV_END) ? result_q : '0;
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor checks them as ready_o rises.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    div_unit #(
        .DATA_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div),
        .opdata1_i   (op1),
        .opdata2_i   (op2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result),
        .ready_o     (ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising ready_o consumes one expected result.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got result %h with no pending request", result);
                end else begin
                    chk("result", result, exp_q.pop_front());
                end
            end
            prev = ready;
        end
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
        logic        scramble;
    } vec_t;

    vec_t vecs[10] = '{
        '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 0, 1'b0},
        '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 0, 1'b0},
        '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 0, 1'b0},
        '{1'b0, 32'd1234,       32'd0,          64'h00000000_00000000, 0, 1'b0},
        '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 0, 1'b0},
        '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 5, 1'b0},
        '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 0, 1'b0},
        '{1'b0, 32'hFFFFFFFF,   32'h10,         64'h0000000F_0FFFFFFF, 0, 1'b0},
        '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 0, 1'b0},
        '{1'b0, 32'd1000,       32'd30,         64'h0000000A_00000021, 0, 1'b1}
    };

    task automatic run_div(input vec_t v);
        int cyc;
        int busy_cycles;
        int lat;
        int exp_busy;
        lat      = (v.b == 0) ? 2 : 34;
        exp_busy = (v.b == 0) ? 1 : 33;
        @(negedge clk);
        signed_div = v.sgn;
        op1 = v.a;
        op2 = v.b;
        start = 1'b1;
        exp_q.push_back(v.exp);
        cyc = 0;
        busy_cycles = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cycles++;
            if (ready) break;
            if (v.scramble && cyc == 5) begin
                op1 = 32'hDEADBEEF;
                op2 = 32'h3;
                signed_div = 1'b1;
            end
        end
        chk("latency", 64'(cyc), 64'(lat));
        chk("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_ready", 64'(ready), 64'd1);
            chk("hold_result", result, v.exp);
        end
        start = 1'b0;
        @(negedge clk);
        chk("release_ready", 64'(ready), 64'd0);
        chk("release_result", result, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        signed_div = 1'b0;
        op1 = '0;
        op2 = '0;
        start = 1'b0;
        annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_div(vecs[i]);

        // Annul at cycle 10 of ON: FREE in cycle 11, no result ever.
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd500;
        op2 = 32'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        chk("annul_busy", 64'(busy), 64'd0);
        chk("annul_ready", 64'(ready), 64'd0);
        start = 1'b0;
        annul = 1'b0;
        begin
            int rose;
            rose = 0;
            repeat (40) begin
                @(negedge clk);
                if (ready) rose = 1;
            end
            chk("annul_no_ready", 64'(rose), 64'd0);
        end

        // Annul while FREE blocks the start.
        @(negedge clk);
        op1 = 32'd9;
        op2 = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        @(negedge clk);
        chk("annul_free_busy", 64'(busy), 64'd0);
        start = 1'b0;
        annul = 1'b0;

        // Reset at cycle 20 aborts immediately.
        @(negedge clk);
        op1 = 32'd777;
        op2 = 32'd5;
        start = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        annul = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        annul = 1'b0;
        start = 1'b0;

        // Fresh divide after the abort: 777 / 5 = 155 r 2.
        run_div('{1'b0, 32'd777, 32'd5, 64'h00000002_0000009B, 0, 1'b0});

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
